// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
// Shared CPU definitions: interrupt FSM states and default datapath widths.
package cpu_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_INDEX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    SERVICE,
    RETURN
  } irq_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
`timescale 1ns/1ps
// Lowest-set-bit priority encoder: channel 0 has the highest priority.
module irq_priority_encoder #(
  parameter int CHANNELS = 8,
  parameter int INDEX_W  = 4
) (
  input  logic [CHANNELS-1:0] req,
  output logic [INDEX_W-1:0]  index,
  output logic                valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req[i]) index = INDEX_W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/interrupt_controller.sv
`timescale 1ns/1ps
// Interrupt controller: edge-latched hardware channels with a mask, a one-deep
// software request slot, and a take/service/return sequencer that redirects
// fetch to the vector on entry and back to the saved PC/IR on return.
module interrupt_controller
  import cpu_pkg::*;
#(
  parameter int               WIDTH         = DEFAULT_WIDTH,
  parameter int               CHANNELS      = 8,
  parameter int               INDEX_W       = DEFAULT_INDEX_W,
  parameter logic [WIDTH-1:0] VECTOR_BASE   = 16'h0004,
  parameter int               VECTOR_STRIDE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] hwIrq,
  input  logic                swIrq,
  input  logic [INDEX_W-1:0]  swIndex,
  input  logic                maskWrite,
  input  logic [CHANNELS-1:0] maskData,
  input  logic                eret,
  input  logic                stall,
  input  logic [WIDTH-1:0]    normalNextPC,
  input  logic [WIDTH-1:0]    fetchIR,
  output logic                interruptOccurs,
  output logic [WIDTH-1:0]    redirectPC,
  output logic [WIDTH-1:0]    savedIR,
  output logic [INDEX_W-1:0]  activeIndex,
  output logic [CHANNELS-1:0] pending,
  output logic                inService
);

  irq_state_t          state;
  logic [CHANNELS-1:0] hwPrev;
  logic [CHANNELS-1:0] mask;
  logic                swPending;
  logic [INDEX_W-1:0]  swIdx;
  logic                takenSw;
  logic [WIDTH-1:0]    savedPC;

  logic [CHANNELS-1:0] hwRise;
  logic [CHANNELS-1:0] pendClear;
  logic                swClear;
  logic [INDEX_W-1:0]  hwIndex;
  logic                hwValid;
  logic [INDEX_W-1:0]  selIndex;
  logic                selValid;

  // Handler address for a given interrupt index, wrapping at the PC width.
  function automatic logic [WIDTH-1:0] vectorFor(input logic [INDEX_W-1:0] idx);
    return VECTOR_BASE + WIDTH'(idx) * WIDTH'(VECTOR_STRIDE);
  endfunction

  assign hwRise = hwIrq & ~hwPrev;

  irq_priority_encoder #(
    .CHANNELS (CHANNELS),
    .INDEX_W  (INDEX_W)
  ) uEncoder (
    .req   (pending & mask),
    .index (hwIndex),
    .valid (hwValid)
  );

  // Software requests always win over any enabled hardware channel.
  always_comb begin
    selValid = swPending | hwValid;
    selIndex = swPending ? swIdx : hwIndex;
  end

  // Retire the serviced request as the handler is actually entered.
  always_comb begin
    pendClear = '0;
    swClear   = 1'b0;
    if (state == TAKE && !stall) begin
      if (takenSw) begin
        swClear = 1'b1;
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (INDEX_W'(i) == activeIndex) pendClear[i] = 1'b1;
        end
      end
    end
  end

  // Request latching plus the take/service/return sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      hwPrev          <= '0;
      pending         <= '0;
      mask            <= '1;
      swPending       <= 1'b0;
      swIdx           <= '0;
      takenSw         <= 1'b0;
      savedPC         <= '0;
      savedIR         <= '0;
      activeIndex     <= '0;
      interruptOccurs <= 1'b0;
      redirectPC      <= '0;
      inService       <= 1'b0;
    end else begin
      hwPrev  <= hwIrq;
      pending <= (pending & ~pendClear) | hwRise;
      if (maskWrite) mask <= maskData;
      if (swIrq) begin
        swPending <= 1'b1;
        swIdx     <= swIndex;
      end else if (swClear) begin
        swPending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (selValid) begin
            state           <= TAKE;
            activeIndex     <= selIndex;
            takenSw         <= swPending;
            savedPC         <= normalNextPC;
            savedIR         <= fetchIR;
            redirectPC      <= vectorFor(selIndex);
            interruptOccurs <= 1'b1;
          end
        end
        TAKE: begin
          if (!stall) begin
            state           <= SERVICE;
            interruptOccurs <= 1'b0;
            inService       <= 1'b1;
          end
        end
        SERVICE: begin
          if (eret) begin
            state           <= RETURN;
            redirectPC      <= savedPC;
            interruptOccurs <= 1'b1;
          end
        end
        RETURN: begin
          if (!stall) begin
            state           <= IDLE;
            interruptOccurs <= 1'b0;
            inService       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
`timescale 1ns/1ps
// Bench for interrupt_controller: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a behavioural model.
module tb_interrupt_controller;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 8;
  localparam int INDEX_W  = 4;
  localparam int VBASE    = 4;
  localparam int VSTRIDE  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [CHANNELS-1:0] hwIrq;
  logic                swIrq;
  logic [INDEX_W-1:0]  swIndex;
  logic                maskWrite;
  logic [CHANNELS-1:0] maskData;
  logic                eret;
  logic                stall;
  logic [WIDTH-1:0]    normalNextPC;
  logic [WIDTH-1:0]    fetchIR;
  logic                interruptOccurs;
  logic [WIDTH-1:0]    redirectPC;
  logic [WIDTH-1:0]    savedIR;
  logic [INDEX_W-1:0]  activeIndex;
  logic [CHANNELS-1:0] pending;
  logic                inService;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [CHANNELS-1:0] hw;
    logic                sw;
    logic [INDEX_W-1:0]  swIdx;
    logic                eret;
    logic                stall;
    logic                expOcc;
    logic [WIDTH-1:0]    expPC;
    logic [INDEX_W-1:0]  expIdx;
    logic [CHANNELS-1:0] expPend;
    logic                expSvc;
  } vec_t;

  // Behavioural model: handler phase as a name, requests as plain bit arrays.
  string mPhase;
  bit    mPend [CHANNELS];
  bit    mMask [CHANNELS];
  bit    mPrev [CHANNELS];
  bit    mSwPend;
  int    mSwIdx;
  int    mActive;
  bit    mTakenSw;
  int    mSavedPC;
  int    mSavedIR;
  int    mRedirect;

  interrupt_controller dut (
    .clk             (clk),
    .rst             (rst),
    .hwIrq           (hwIrq),
    .swIrq           (swIrq),
    .swIndex         (swIndex),
    .maskWrite       (maskWrite),
    .maskData        (maskData),
    .eret            (eret),
    .stall           (stall),
    .normalNextPC    (normalNextPC),
    .fetchIR         (fetchIR),
    .interruptOccurs (interruptOccurs),
    .redirectPC      (redirectPC),
    .savedIR         (savedIR),
    .activeIndex     (activeIndex),
    .pending         (pending),
    .inService       (inService)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    mPhase = "idle";
    for (int i = 0; i < CHANNELS; i++) begin
      mPend[i] = 1'b0;
      mMask[i] = 1'b1;
      mPrev[i] = 1'b0;
    end
    mSwPend   = 1'b0;
    mSwIdx    = 0;
    mActive   = 0;
    mTakenSw  = 1'b0;
    mSavedPC  = 0;
    mSavedIR  = 0;
    mRedirect = 0;
  endtask

  task automatic modelStep();
    string nextPhase = mPhase;
    int    clearHw   = -1;
    bit    clearSw   = 1'b0;
    if (mPhase == "idle") begin
      int sel = -1;
      if (mSwPend) begin
        sel = mSwIdx;
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (mPend[i] && mMask[i]) begin
            sel = i;
            break;
          end
        end
      end
      if (sel >= 0) begin
        nextPhase = "take";
        mActive   = sel;
        mTakenSw  = mSwPend;
        mSavedPC  = int'(normalNextPC);
        mSavedIR  = int'(fetchIR);
        mRedirect = (VBASE + sel * VSTRIDE) % 65536;
      end
    end else if (mPhase == "take") begin
      if (!stall) begin
        nextPhase = "service";
        if (mTakenSw) clearSw = 1'b1;
        else clearHw = mActive;
      end
    end else if (mPhase == "service") begin
      if (eret) begin
        nextPhase = "return";
        mRedirect = mSavedPC;
      end
    end else begin
      if (!stall) nextPhase = "idle";
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (i == clearHw) mPend[i] = 1'b0;
      if (hwIrq[i] && !mPrev[i]) mPend[i] = 1'b1;
      mPrev[i] = hwIrq[i];
      if (maskWrite) mMask[i] = maskData[i];
    end
    if (clearSw) mSwPend = 1'b0;
    if (swIrq) begin
      mSwPend = 1'b1;
      mSwIdx  = int'(swIndex);
    end
    mPhase = nextPhase;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: the model advances on the same edge, outputs are read 1ns later.
  task automatic applyStimulus();
    @(posedge clk);
    if (!rst) modelReset();
    else modelStep();
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [CHANNELS-1:0] ePend;
    bit eOcc;
    bit eSvc;
    for (int i = 0; i < CHANNELS; i++) ePend[i] = mPend[i];
    eOcc = (mPhase == "take") || (mPhase == "return");
    eSvc = (mPhase == "service") || (mPhase == "return");
    checkValue({tag, ".occ"}, 32'(interruptOccurs), 32'(eOcc));
    checkValue({tag, ".inService"}, 32'(inService), 32'(eSvc));
    checkValue({tag, ".pending"}, 32'(pending), 32'(ePend));
    checkValue({tag, ".savedIR"}, 32'(savedIR), 32'(mSavedIR));
    if (eOcc) checkValue({tag, ".redirectPC"}, 32'(redirectPC), 32'(mRedirect));
    if (eOcc || eSvc) checkValue({tag, ".activeIndex"}, 32'(activeIndex), 32'(mActive));
  endtask

  initial begin
    vec_t vecs[$];

    rst = 1'b0; hwIrq = '0; swIrq = 1'b0; swIndex = '0; maskWrite = 1'b0;
    maskData = '0; eret = 1'b0; stall = 1'b0;
    normalNextPC = 16'h0100; fetchIR = 16'hABCD;
    modelReset();

    repeat (2) applyStimulus();
    checkValue("reset.occ", 32'(interruptOccurs), 32'h0);
    checkValue("reset.inService", 32'(inService), 32'h0);
    checkValue("reset.pending", 32'(pending), 32'h0);
    checkValue("reset.redirectPC", 32'(redirectPC), 32'h0);
    checkValue("reset.savedIR", 32'(savedIR), 32'h0);
    checkValue("reset.activeIndex", 32'(activeIndex), 32'h0);
    rst = 1'b1;

    // hw, sw, swIdx, eret, stall | occ, redirectPC, activeIndex, pending, inService
    vecs.push_back('{8'h08, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 8'h08, 1'b0});
    vecs.push_back('{8'h08, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h000A, 4'd3, 8'h08, 1'b0});
    vecs.push_back('{8'h08, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd3, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0100, 4'd3, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 8'h00, 1'b0});
    vecs.push_back('{8'h22, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 8'h22, 1'b0});
    vecs.push_back('{8'h22, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0006, 4'd1, 8'h22, 1'b0});
    vecs.push_back('{8'h22, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd1, 8'h20, 1'b1});
    vecs.push_back('{8'h22, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0100, 4'd1, 8'h20, 1'b1});
    vecs.push_back('{8'h22, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 8'h20, 1'b0});
    vecs.push_back('{8'h22, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h000E, 4'd5, 8'h20, 1'b0});
    vecs.push_back('{8'h22, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd5, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0100, 4'd5, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 8'h00, 1'b0});
    vecs.push_back('{8'h01, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 8'h01, 1'b0});
    vecs.push_back('{8'h01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0016, 4'd9, 8'h01, 1'b0});
    vecs.push_back('{8'h01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd9, 8'h01, 1'b1});
    vecs.push_back('{8'h01, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0100, 4'd9, 8'h01, 1'b1});
    vecs.push_back('{8'h01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 8'h01, 1'b0});
    vecs.push_back('{8'h01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0004, 4'd0, 8'h01, 1'b0});
    vecs.push_back('{8'h01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0100, 4'd0, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 8'h00, 1'b0});

    for (int r = 0; r < vecs.size(); r++) begin
      hwIrq = vecs[r].hw; swIrq = vecs[r].sw; swIndex = vecs[r].swIdx;
      eret = vecs[r].eret; stall = vecs[r].stall;
      applyStimulus();
      checkValue($sformatf("vec%0d.occ", r), 32'(interruptOccurs), 32'(vecs[r].expOcc));
      checkValue($sformatf("vec%0d.inService", r), 32'(inService), 32'(vecs[r].expSvc));
      checkValue($sformatf("vec%0d.pending", r), 32'(pending), 32'(vecs[r].expPend));
      if (vecs[r].expOcc)
        checkValue($sformatf("vec%0d.redirectPC", r), 32'(redirectPC), 32'(vecs[r].expPC));
      if (vecs[r].expOcc || vecs[r].expSvc)
        checkValue($sformatf("vec%0d.activeIndex", r), 32'(activeIndex), 32'(vecs[r].expIdx));
    end
    swIrq = 1'b0; eret = 1'b0; stall = 1'b0; hwIrq = '0;

    // Masked channel latches but is not taken until the mask reopens.
    maskWrite = 1'b1; maskData = 8'hFB;
    applyStimulus(); checkOutput("mask.write");
    maskWrite = 1'b0; hwIrq = 8'h04;
    applyStimulus(); checkOutput("mask.latch");
    checkValue("mask.pend2", 32'(pending[2]), 32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(); checkOutput($sformatf("mask.hold%0d", k));
      checkValue($sformatf("mask.noTake%0d", k), 32'(interruptOccurs), 32'h0);
    end
    maskWrite = 1'b1; maskData = 8'hFF;
    applyStimulus(); checkOutput("mask.reopen");
    checkValue("mask.oldMaskUsed", 32'(interruptOccurs), 32'h0);
    maskWrite = 1'b0;
    applyStimulus(); checkOutput("mask.take");
    checkValue("mask.takeOcc", 32'(interruptOccurs), 32'h1);
    checkValue("mask.takePC", 32'(redirectPC), 32'h0008);
    checkValue("mask.takeIdx", 32'(activeIndex), 32'h2);
    applyStimulus(); checkOutput("mask.service");
    eret = 1'b1; applyStimulus(); checkOutput("mask.return");
    eret = 1'b0; applyStimulus(); checkOutput("mask.idle");
    hwIrq = '0;

    // Stalled TAKE and RETURN hold their redirect; capture happens at entry only.
    hwIrq = 8'h10;
    applyStimulus(); checkOutput("stall.latch");
    normalNextPC = 16'h1234; fetchIR = 16'h5A5A; stall = 1'b1;
    applyStimulus(); checkOutput("stall.take0");
    checkValue("stall.occ0", 32'(interruptOccurs), 32'h1);
    checkValue("stall.pc0", 32'(redirectPC), 32'h000C);
    normalNextPC = 16'h2222; fetchIR = 16'h3333;
    for (int k = 1; k < 4; k++) begin
      applyStimulus(); checkOutput($sformatf("stall.take%0d", k));
      checkValue($sformatf("stall.occ%0d", k), 32'(interruptOccurs), 32'h1);
      checkValue($sformatf("stall.pc%0d", k), 32'(redirectPC), 32'h000C);
    end
    stall = 1'b0;
    applyStimulus(); checkOutput("stall.service");
    checkValue("stall.svcOcc", 32'(interruptOccurs), 32'h0);
    checkValue("stall.svcIn", 32'(inService), 32'h1);
    eret = 1'b1; stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(); checkOutput($sformatf("stall.ret%0d", k));
      eret = 1'b0;
      checkValue($sformatf("stall.retOcc%0d", k), 32'(interruptOccurs), 32'h1);
      checkValue($sformatf("stall.retPC%0d", k), 32'(redirectPC), 32'h1234);
      checkValue($sformatf("stall.retIR%0d", k), 32'(savedIR), 32'h5A5A);
    end
    stall = 1'b0;
    applyStimulus(); checkOutput("stall.idle");
    checkValue("stall.idleOcc", 32'(interruptOccurs), 32'h0);
    checkValue("stall.idleIn", 32'(inService), 32'h0);
    hwIrq = '0;

    // Asynchronous reset in the middle of a handler drops everything in flight.
    hwIrq = 8'hC0;
    applyStimulus(); applyStimulus(); checkOutput("rstSeq.take");
    applyStimulus(); checkOutput("rstSeq.service");
    checkValue("rstSeq.inService", 32'(inService), 32'h1);
    checkValue("rstSeq.pending", 32'(pending), 32'h80);
    swIrq = 1'b1; swIndex = 4'd3;
    applyStimulus(); checkOutput("rstSeq.swQueued");
    swIrq = 1'b0;
    #1 rst = 1'b0;
    #2;
    checkValue("rstSeq.asyncOcc", 32'(interruptOccurs), 32'h0);
    checkValue("rstSeq.asyncIn", 32'(inService), 32'h0);
    checkValue("rstSeq.asyncPend", 32'(pending), 32'h0);
    checkValue("rstSeq.asyncPC", 32'(redirectPC), 32'h0);
    checkValue("rstSeq.asyncIR", 32'(savedIR), 32'h0);
    checkValue("rstSeq.asyncIdx", 32'(activeIndex), 32'h0);
    hwIrq = '0;
    applyStimulus(); checkOutput("rstSeq.held");
    rst = 1'b1; eret = 1'b1;
    applyStimulus(); checkOutput("rstSeq.eret");
    eret = 1'b0;
    checkValue("rstSeq.eretOcc", 32'(interruptOccurs), 32'h0);
    checkValue("rstSeq.eretIn", 32'(inService), 32'h0);
    applyStimulus(); checkOutput("rstSeq.quiet");
    checkValue("rstSeq.noTake", 32'(interruptOccurs), 32'h0);

    // Randomized traffic, including occasional resets, against the model.
    for (int c = 0; c < 1500; c++) begin
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
      hwIrq        ^= CHANNELS'($urandom & $urandom & $urandom);
      swIrq         = ($urandom_range(0, 11) == 0);
      swIndex       = INDEX_W'($urandom);
      eret          = ($urandom_range(0, 3) == 0);
      stall         = ($urandom_range(0, 2) == 0);
      maskWrite     = ($urandom_range(0, 39) == 0);
      maskData      = CHANNELS'($urandom);
      normalNextPC  = WIDTH'($urandom);
      fetchIR       = WIDTH'($urandom);
      applyStimulus();
      checkOutput($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
